missile_pool_control: RTL
=========================

Name: missile_pool_control

Overview:
- Parametrised successor of the single-missile flight/explosion controller.
- Manages NUM_CH independent missile slots. A single launch request is allocated to the lowest-numbered free slot.
- Each slot tracks flight until its Y position reaches the ground or a collision hit arrives, then runs a frame-timed blast animation.
- Sits between player/enemy fire logic and the missile position and sprite units.

Parameters:
- NUM_CH, 4, number of missile slots (1..8)
- Y_W, 10, width of each Y position
- GROUND_Y, 390, Y value at or beyond which a flying missile detonates
- BLAST_FRAMES, 8, number of frame_tick pulses the blast lasts (1..15; 0 illegal)
- IDX_W, 2, width of slot index; must satisfy 2**IDX_W >= NUM_CH

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- launch  in  1  fire request, sampled every cycle
- frame_tick  in  1  one-cycle pulse per video frame (vsync)
- hit  in  NUM_CH  per-slot collision detonation request
- missle_Y_Pos_in  in  NUM_CH*Y_W  packed per-slot Y positions; slot i is bits [i*Y_W +: Y_W]
- launch_ack  out  1  launch accepted this cycle (combinational)
- launch_ch  out  IDX_W  slot granted (valid when launch_ack=1, else 0)
- pool_full  out  1  no slot in Wait (combinational)
- explored  out  NUM_CH  1 = slot not in flight; 0 = in flight
- exploding  out  NUM_CH  1 = slot in Blast
- blast_frame  out  NUM_CH*4  packed per-slot blast frame index
- done_pulse  out  NUM_CH  one-cycle pulse when slot finishes its blast

Behaviour:
- Reset (synchronous, active-high): all slots go to Wait and blast counters clear.
  - Outputs after reset: explored all 1s, exploding 0, blast_frame 0, done_pulse 0, launch_ack 0, launch_ch 0, pool_full 0.
  - Reset asserted mid-flight or mid-blast aborts the slot immediately, with no done_pulse.
- Per-slot FSM states: Wait, Flight, Blast, Done.
  - Wait: if this slot is granted, go to Flight next cycle; otherwise stay.
  - Flight: if hit[i]=1 or Y_i >= GROUND_Y (unsigned compare), go to Blast and clear the counter; otherwise stay.
  - Blast: on frame_tick, increment the counter. If frame_tick=1 and counter==BLAST_FRAMES-1, go to Done. Without frame_tick, hold.
  - Done: one cycle, done_pulse[i]=1, then go to Wait.
- Allocation:
  - launch_ack = launch AND (any slot in Wait).
  - launch_ch = index of the lowest-numbered Wait slot.
  - Only one slot is granted per cycle.
  - A launch while pool_full=1 is dropped (launch_ack=0) and is not queued.
  - A slot in Done is not free until it returns to Wait the following cycle.
- Latency:
  - Grant cycle N: slot enters Flight at N+1, so explored[i] falls at N+1.
  - Detonate condition at cycle M: slot enters Blast at M+1.
  - Blast lasts exactly BLAST_FRAMES frame_tick pulses. The Done state follows the cycle of the final tick.
- Outputs are registered and decoded from state:
  - explored[i]=0 only in Flight.
  - exploding[i]=1 only in Blast.
  - blast_frame[i] equals the counter in Blast, else 0.
- Simultaneous events:
  - hit and ground crossing in the same cycle cause a single transition to Blast.
  - hit[i] and Y_i are ignored outside Flight.
  - frame_tick in the cycle a slot enters Blast does not count; counting begins in Blast.
  - Launch and a Done->Wait transition in the same cycle: that slot is not yet eligible.
- Width rules:
  - The counter is 4 bits and never exceeds BLAST_FRAMES-1.
  - The Y compare is an unsigned Y_W-bit compare with GROUND_Y truncated to Y_W.

Test Plan:
- Reset, then launch=1 for one cycle -> launch_ack=1 and launch_ch=0 that cycle; explored=4'b1110 next cycle. Drive Y0 from 100 up to 390 -> exploding[0]=1 the cycle after Y0=390.
- Slot 0 in Blast with BLAST_FRAMES=8; issue 8 frame_ticks spaced 10 cycles apart -> blast_frame steps 0..7. done_pulse[0] fires the cycle after the 8th tick, and slot 0 is granted again on the next launch.
- Four launches on consecutive cycles, then a fifth -> launch_ch 0,1,2,3. pool_full=1 on the fifth, with launch_ack=0 and no state change.
- Slots 0-2 flying at Y=200; hit=3'b010 -> only slot 1 enters Blast. The next launch gets launch_ch=1 only after slot 1's done_pulse plus one cycle; before that, with slot 3 free, launch_ch=3.
- hit[2]=1 and Y2=395 in the same cycle -> exactly one Blast entry with blast_frame starting at 0. frame_tick coincident with Blast entry is not counted (done after 8 further ticks).
- Reset asserted while slot 0 is in Blast at frame 5 -> next cycle explored all 1s, exploding 0, blast_frame 0, and no done_pulse.

Source files
------------

// File: rtl/missile_pool_control.sv
// missile_pool_control
// Pool of NUM_CH independent missile slots. A launch request is granted to the
// lowest-numbered slot in Wait; each slot then flies until it reaches the ground
// or is hit, runs a frame-timed blast animation, and signals completion with a
// one-cycle done_pulse before becoming free again.
module missile_pool_control #(
    parameter int NUM_CH       = 4,
    parameter int Y_W          = 10,
    parameter int GROUND_Y     = 390,
    parameter int BLAST_FRAMES = 8,
    parameter int IDX_W        = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  launch,
    input  logic                  frame_tick,
    input  logic [NUM_CH-1:0]     hit,
    input  logic [NUM_CH*Y_W-1:0] missle_Y_Pos_in,
    output logic                  launch_ack,
    output logic [IDX_W-1:0]      launch_ch,
    output logic                  pool_full,
    output logic [NUM_CH-1:0]     explored,
    output logic [NUM_CH-1:0]     exploding,
    output logic [NUM_CH*4-1:0]   blast_frame,
    output logic [NUM_CH-1:0]     done_pulse
);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_FLIGHT = 2'd1;
    localparam logic [1:0] S_BLAST  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [Y_W-1:0] GROUND_T   = Y_W'(GROUND_Y);
    localparam logic [3:0]     LAST_FRAME = 4'(BLAST_FRAMES - 1);

    logic [1:0]        state_q [NUM_CH];
    logic [1:0]        state_d [NUM_CH];
    logic [3:0]        cnt_q   [NUM_CH];
    logic [3:0]        cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] grant;
    logic              found;

    // Allocation: grant the lowest-numbered Wait slot; a slot in Done is not free yet
    always_comb begin
        free      = '0;
        grant     = '0;
        launch_ch = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            free[i] = (state_q[i] == S_WAIT);
            if (launch && free[i] && !found) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                launch_ch = IDX_W'(i);
            end
        end
        launch_ack = found;
        pool_full  = ~|free;
    end

    // Per-slot next state and blast frame counter
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_WAIT: begin
                    if (grant[i]) state_d[i] = S_FLIGHT;
                end
                S_FLIGHT: begin
                    if (hit[i] || (missle_Y_Pos_in[i*Y_W +: Y_W] >= GROUND_T)) begin
                        state_d[i] = S_BLAST;
                        cnt_d[i]   = '0;
                    end
                end
                S_BLAST: begin
                    // The final tick leaves the counter at LAST_FRAME rather than wrapping
                    if (frame_tick) begin
                        if (cnt_q[i] == LAST_FRAME) state_d[i] = S_DONE;
                        else                        cnt_d[i]   = cnt_q[i] + 4'd1;
                    end
                end
                S_DONE:  state_d[i] = S_WAIT;
                default: state_d[i] = S_WAIT;
            endcase
        end
    end

    // State registers with synchronous reset that aborts any slot without done_pulse
    always_ff @(posedge Clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (Reset) begin
                state_q[i] <= S_WAIT;
                cnt_q[i]   <= '0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Status outputs decoded from the registered slot states
    always_comb begin
        explored    = '1;
        exploding   = '0;
        blast_frame = '0;
        done_pulse  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            explored[i]   = (state_q[i] != S_FLIGHT);
            exploding[i]  = (state_q[i] == S_BLAST);
            done_pulse[i] = (state_q[i] == S_DONE);
            if (state_q[i] == S_BLAST) blast_frame[i*4 +: 4] = cnt_q[i];
        end
    end

endmodule
